// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the CPU memory port
// (initiator, master modport) and the memory responder (slave modport).
//   req        initiator -> responder  request strobe
//   mem_op     initiator -> responder  0 = read, 1 = write
//   addr       initiator -> responder  byte address
//   wdata      initiator -> responder  write data (register B)
//   byte_en    initiator -> responder  write lane enables (MEMRESP_BYTE_LANE_EN only)
//   rdata      responder -> initiator  read data / write echo, valid with ready
//   ready      responder -> initiator  one-cycle response pulse
//   misaligned responder -> initiator  misaligned-access flag, valid with ready
//   busy       responder -> initiator  transaction in progress
// Optional feature macro: MEMRESP_BYTE_LANE_EN adds the byte_en signal.
interface mem_responder_if;
    logic        req;
    logic        mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef MEMRESP_BYTE_LANE_EN
    logic [3:0]  byte_en;
`endif
    logic [31:0] rdata;
    logic        ready;
    logic        misaligned;
    logic        busy;

`ifdef MEMRESP_BYTE_LANE_EN
    modport master (output req, mem_op, addr, wdata, byte_en,
                    input  rdata, ready, misaligned, busy);
    modport slave  (input  req, mem_op, addr, wdata, byte_en,
                    output rdata, ready, misaligned, busy);
`else
    modport master (output req, mem_op, addr, wdata,
                    input  rdata, ready, misaligned, busy);
    modport slave  (input  req, mem_op, addr, wdata,
                    output rdata, ready, misaligned, busy);
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM that services CPU memory requests with a
// configurable number of wait states. A request accepted in IDLE is answered
// with a one-cycle ready pulse WAIT_STATES+1 cycles later; misaligned word
// accesses are answered with rdata=0 and misaligned=1 and never write RAM.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset (RAM contents are kept)
//   bus    mem_responder_if.slave (req, mem_op, addr, wdata, [byte_en],
//          rdata, ready, misaligned, busy)
// Parameters:
//   DEPTH_WORDS  number of 32-bit words, power of 2, >= 4
//   WAIT_STATES  extra cycles between acceptance and response, 0..15
// Optional feature macro: MEMRESP_BYTE_LANE_EN (per-byte write enables).
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1
) (
    input logic          clk,
    input logic          reset,
    mem_responder_if.slave bus
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [3:0]       waitCnt;
    logic [IDX_W+1:0] addrLat;
    logic             opLat;
    logic [31:0]      wdataLat;
    logic [31:0]      rdataReg;
    logic             readyReg;
    logic             misReg;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             doAccess;
    logic [IDX_W+1:0] accAddr;
    logic             accOp;
    logic [31:0]      accWdata;
    logic [IDX_W-1:0] accIdx;
    logic             aligned;
    logic [31:0]      curWord;
    logic [31:0]      newWord;

`ifdef MEMRESP_BYTE_LANE_EN
    logic [3:0]       byteEnLat;
    logic [3:0]       accBe;
`endif

    assign accept = (state == ST_IDLE) && bus.req;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the access operands come straight from the bus in that case.
    assign doAccess = (accept && (WAIT_CNT == 4'd0)) ||
                      ((state == ST_WAIT) && (waitCnt == 4'd1));

    assign accAddr  = accept ? bus.addr[IDX_W+1:0] : addrLat;
    assign accOp    = accept ? bus.mem_op          : opLat;
    assign accWdata = accept ? bus.wdata           : wdataLat;
`ifdef MEMRESP_BYTE_LANE_EN
    assign accBe    = accept ? bus.byte_en         : byteEnLat;
`endif

    // Upper address bits are dropped, so addresses wrap modulo the RAM size.
    assign accIdx  = accAddr[IDX_W+1:2];
    assign aligned = (accAddr[1:0] == 2'b00);
    assign curWord = mem[accIdx];

`ifdef MEMRESP_BYTE_LANE_EN
    always_comb begin
        newWord = curWord;
        for (int i = 0; i < 4; i++) begin
            if (accBe[i]) begin
                newWord[8*i +: 8] = accWdata[8*i +: 8];
            end
        end
    end
`else
    assign newWord = accWdata;
`endif

    // RAM is never cleared; reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && doAccess && accOp && aligned) begin
            mem[accIdx] <= newWord;
        end
    end

    // Request operands are captured on acceptance and held for the access.
    always_ff @(posedge clk) begin
        if (accept) begin
            addrLat   <= bus.addr[IDX_W+1:0];
            opLat     <= bus.mem_op;
            wdataLat  <= bus.wdata;
`ifdef MEMRESP_BYTE_LANE_EN
            byteEnLat <= bus.byte_en;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            waitCnt  <= 4'd0;
            rdataReg <= 32'd0;
            readyReg <= 1'b0;
            misReg   <= 1'b0;
        end else begin
            // ready/misaligned are only ever high for the single RESP cycle.
            readyReg <= 1'b0;
            misReg   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        waitCnt <= WAIT_CNT;
                        state   <= (WAIT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // rdata only changes on an access edge and holds otherwise.
            if (doAccess) begin
                readyReg <= 1'b1;
                misReg   <= !aligned;
                if (!aligned) begin
                    rdataReg <= 32'd0;
                end else if (accOp) begin
                    rdataReg <= newWord;
                end else begin
                    rdataReg <= curWord;
                end
            end
        end
    end

    assign bus.rdata      = rdataReg;
    assign bus.ready      = readyReg;
    assign bus.misaligned = misReg;
    assign bus.busy       = (state == ST_WAIT) || (state == ST_RESP);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (WAIT_STATES 0, 1, 3; DEPTH_WORDS 64)
// share one clock, reset and operand bus, each with its own req line.
// Expected responses come from a word-array model of RAM and the latency
// rule ready-at-cycle T+1+WAIT_STATES.
// Optional feature macro: MEMRESP_BYTE_LANE_EN enables the byte-lane tests.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  reqV;
    logic        opS;
    logic [31:0] addrS;
    logic [31:0] wdS;
    logic [3:0]  beS;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus3 ();

    assign bus0.req = reqV[0];  assign bus0.mem_op = opS;
    assign bus0.addr = addrS;   assign bus0.wdata = wdS;
    assign bus1.req = reqV[1];  assign bus1.mem_op = opS;
    assign bus1.addr = addrS;   assign bus1.wdata = wdS;
    assign bus3.req = reqV[2];  assign bus3.mem_op = opS;
    assign bus3.addr = addrS;   assign bus3.wdata = wdS;
`ifdef MEMRESP_BYTE_LANE_EN
    assign bus0.byte_en = beS;
    assign bus1.byte_en = beS;
    assign bus3.byte_en = beS;
`endif

    mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    logic [2:0]  rdyV, bsyV, misV;
    logic [31:0] rdV [3];
    assign rdyV = {bus3.ready, bus1.ready, bus0.ready};
    assign bsyV = {bus3.busy, bus1.busy, bus0.busy};
    assign misV = {bus3.misaligned, bus1.misaligned, bus0.misaligned};
    assign rdV[0] = bus0.rdata;
    assign rdV[1] = bus1.rdata;
    assign rdV[2] = bus3.rdata;

    int nChecks = 0;
    int nErrors = 0;

    logic [31:0] model [3][64];

    typedef struct {
        int          k;
        bit          op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] expR;
        bit          expM;
    } vec_t;

    vec_t vecs [12];

    function automatic int wsOf(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: an access reads or updates one word of a 64-word array;
    // any address with nonzero low bits returns 0 and sets the error flag.
    task automatic modelAccess(input int k, input bit op, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be,
                               output logic [31:0] expR, output bit expM);
        int          idx;
        logic [31:0] w;
        logic [3:0]  lanes;
        idx = int'((a / 32'd4) % 32'd64);
`ifdef MEMRESP_BYTE_LANE_EN
        lanes = be;
`else
        lanes = 4'hF | be;
`endif
        if ((a % 32'd4) != 0) begin
            expR = 32'd0;
            expM = 1'b1;
        end else if (op) begin
            w = model[k][idx];
            for (int i = 0; i < 4; i++)
                if (lanes[i]) w[8*i +: 8] = wd[8*i +: 8];
            model[k][idx] = w;
            expR = w;
            expM = 1'b0;
        end else begin
            expR = model[k][idx];
            expM = 1'b0;
        end
    endtask

    // One transaction on responder k; checks every cycle up to and one past
    // the response. With scramble set, req and operands are jiggled while busy.
    task automatic txn(input int k, input bit op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] expR, input bit expM,
                       input bit scramble, input string name);
        int ws;
        ws = wsOf(k);
        @(negedge clk);
        opS = op; addrS = a; wdS = wd; beS = be; reqV[k] = 1'b1;
        for (int c = 1; c <= ws + 1; c++) begin
            @(negedge clk);
            if (c == ws + 1) begin
                chk({name, " ready/busy"}, {30'd0, rdyV[k], bsyV[k]}, 32'd3);
                chk({name, " rdata"}, rdV[k], expR);
                chk({name, " misaligned"}, {31'd0, misV[k]}, {31'd0, expM});
                reqV[k] = 1'b0;
            end else begin
                chk({name, " wait ready/busy"}, {30'd0, rdyV[k], bsyV[k]}, 32'd1);
                if (scramble) begin
                    reqV[k] = 1'($urandom);
                    opS = 1'($urandom); addrS = $urandom; wdS = $urandom; beS = 4'($urandom);
                end else begin
                    reqV[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk({name, " after ready/busy/mis"}, {29'd0, rdyV[k], bsyV[k], misV[k]}, 32'd0);
        chk({name, " rdata hold"}, rdV[k], expR);
    endtask

    task automatic countPulses(input int k, input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (rdyV[k]) n++;
        end
    endtask

    initial begin
        logic [31:0] eR;
        bit          eM;
        int          pulses;
        logic [3:0]  pat;
        logic [31:0] old;

        reset = 1'b1; reqV = 3'b000; opS = 1'b0; addrS = 32'd0; wdS = 32'd0; beS = 4'hF;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d ready/busy/mis", k), {29'd0, rdyV[k], bsyV[k], misV[k]}, 32'd0);
            chk($sformatf("reset%0d rdata", k), rdV[k], 32'd0);
        end
        reset = 1'b0;

        // Fill every word of every responder so the model is fully defined.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 64; w++) begin
                logic [31:0] d;
                d = $urandom;
                modelAccess(k, 1'b1, 32'(w * 4), d, 4'hF, eR, eM);
                txn(k, 1'b1, 32'(w * 4), d, 4'hF, eR, eM, 1'b0, $sformatf("init%0d_%0d", k, w));
            end
        end

        vecs[0]  = '{1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
        vecs[3]  = '{1, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[4]  = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[5]  = '{1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
        vecs[6]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[7]  = '{0, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[8]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0};
        vecs[9]  = '{2, 1'b0, 32'h0000_0003, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{2, 1'b1, 32'hFFFF_FFFC, 32'h600D_CAFE, 32'h600D_CAFE, 1'b0};
        vecs[11] = '{2, 1'b0, 32'h0000_00FC, 32'h0,         32'h600D_CAFE, 1'b0};
        for (int i = 0; i < 12; i++) begin
            modelAccess(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].wd, 4'hF, eR, eM);
            txn(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].wd, 4'hF,
                vecs[i].expR, vecs[i].expM, 1'b0, $sformatf("vec%0d", i));
        end

        // req held through RESP on the zero-wait responder: RESP ignores it,
        // the following IDLE cycle accepts it again -> ready pattern 1,0,1,0.
        modelAccess(0, 1'b0, 32'h0, 32'h0, 4'hF, eR, eM);
        @(negedge clk);
        opS = 1'b0; addrS = 32'h0; reqV[0] = 1'b1;
        @(negedge clk); pat[0] = rdyV[0];
        @(negedge clk); pat[1] = rdyV[0];
        @(negedge clk); pat[2] = rdyV[0];
        chk("heldreq rdata", rdV[0], eR);
        reqV[0] = 1'b0;
        @(negedge clk); pat[3] = rdyV[0];
        chk("heldreq ready pattern", {28'd0, pat}, 32'h5);

        // Reset in the second WAIT cycle of a write aborts it.
        old = model[2][8];
        @(negedge clk);
        opS = 1'b1; addrS = 32'h20; wdS = 32'hCAFE_F00D; reqV[2] = 1'b1;
        @(negedge clk);
        chk("abort wait1 ready/busy", {30'd0, rdyV[2], bsyV[2]}, 32'd1);
        reqV[2] = 1'b0; wdS = 32'h1111_1111;
        @(negedge clk);
        chk("abort wait2 ready/busy", {30'd0, rdyV[2], bsyV[2]}, 32'd1);
        reqV[2] = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("abort reset ready/busy/mis", {29'd0, rdyV[2], bsyV[2], misV[2]}, 32'd0);
        chk("abort reset rdata", rdV[2], 32'd0);
        reset = 1'b0; reqV[2] = 1'b0;
        countPulses(2, 6, pulses);
        chk("abort no ready", 32'(pulses), 32'd0);
        txn(2, 1'b0, 32'h20, 32'h0, 4'hF, old, 1'b0, 1'b0, "abort readback");

        // req toggled while busy must not produce an extra response.
        modelAccess(2, 1'b1, 32'h30, 32'h7777_0001, 4'hF, eR, eM);
        txn(2, 1'b1, 32'h30, 32'h7777_0001, 4'hF, eR, eM, 1'b1, "busyreq");
        countPulses(2, 6, pulses);
        chk("busyreq no extra ready", 32'(pulses), 32'd0);

`ifdef MEMRESP_BYTE_LANE_EN
        modelAccess(1, 1'b1, 32'h40, 32'h1122_3344, 4'hF, eR, eM);
        txn(1, 1'b1, 32'h40, 32'h1122_3344, 4'hF, 32'h1122_3344, 1'b0, 1'b0, "be full");
        modelAccess(1, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, eR, eM);
        txn(1, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 1'b0, 1'b0, "be 0101");
        modelAccess(1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, eR, eM);
        txn(1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 32'h11BB_33DD, 1'b0, 1'b0, "be 0000");
        modelAccess(1, 1'b0, 32'h40, 32'h0, 4'b0000, eR, eM);
        txn(1, 1'b0, 32'h40, 32'h0, 4'b0000, 32'h11BB_33DD, 1'b0, 1'b0, "be read");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int          k;
            bit          op, scr;
            logic [31:0] a, d;
            logic [3:0]  be;
            k   = int'($urandom_range(0, 2));
            op  = 1'($urandom);
            scr = 1'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d   = $urandom;
            be  = 4'($urandom);
            modelAccess(k, op, a, d, be, eR, eM);
            txn(k, op, a, d, be, eR, eM, scr, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU datapath's memory port.
- The CPU (initiator) presents an address, a read/write operation and write data (register B); this block services the request with a configurable number of wait states.
- Returns read data with a one-cycle ready pulse and flags misaligned word accesses so the control unit can raise an exception.
- Word-organised RAM, replacing the fixed-latency memory when multicycle memory timing is exercised.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of 2, minimum 4.
- WAIT_STATES, 1, extra cycles between request acceptance and response; 0 to 15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- mem_op  input  1  0 = read, 1 = write (same encoding as the CPU MemOp signal).
- addr  input  32  byte address.
- wdata  input  32  write data.
- rdata  output  32  registered read data; valid while ready=1.
- ready  output  1  one-cycle response pulse.
- misaligned  output  1  error flag; valid while ready=1.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset: state=IDLE; rdata=0, ready=0, misaligned=0, busy=0; wait counter=0. RAM contents are not cleared. Reset wins over every other event.
- States: IDLE, WAIT, RESP.
- IDLE with req=1 at edge T:
  - Latch addr, mem_op, wdata.
  - Load counter=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else do the access at this edge and go to RESP.
- WAIT: counter decrements each edge. At the edge where counter==1, perform the access and go to RESP.
- RESP: ready=1 for exactly one cycle, then IDLE. Total latency: ready is high in cycle T+1+WAIT_STATES.
- Access rules:
  - Word index = latched addr[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Read: rdata <= RAM[index]; misaligned <= 0.
  - Write: RAM[index] <= wdata; rdata <= wdata (echo); misaligned <= 0.
  - Latched addr[1:0]!=0: no RAM write, rdata <= 0, misaligned <= 1. The response still occurs with normal latency.
- rdata holds its value after ready falls until the next access edge.
- ready and misaligned return to 0 outside RESP.
- req while busy=1 is ignored; it is not queued.
- req held high in RESP is ignored that cycle. If still high in the following IDLE cycle, it is accepted as a new request. The initiator drops req on seeing ready.
- Changes on addr, mem_op or wdata after acceptance have no effect.
- Reset during WAIT aborts the transaction: no write is committed and no ready is issued. Reset on the access edge takes priority, so the write is suppressed.

Optional Feature:
- Macro MEMRESP_BYTE_LANE_EN.
- Defined:
  - Adds input byte_en[3:0], latched on acceptance.
  - On a write, only lanes with byte_en[i]=1 are updated: lane i = bits 8i+7:8i.
  - rdata echoes the full resulting word.
  - byte_en=0000 is a legal write that leaves RAM unchanged.
  - Reads ignore byte_en.
- Not defined: port absent; every write updates all 32 bits.

Test Plan:
- WAIT_STATES=1. Write addr=0x8, wdata=0xDEADBEEF accepted at T -> ready=1 only in T+2, misaligned=0, rdata=0xDEADBEEF. Then read addr=0x8 -> rdata=0xDEADBEEF at T'+2.
- WAIT_STATES=0. Read addr=0x0 after reset, RAM preloaded with 0x12345678 -> ready at T+1, rdata=0x12345678, busy high only in T+1.
- Misaligned write addr=0x6, wdata=0xFFFFFFFF -> ready at normal latency, misaligned=1, rdata=0. A subsequent read of addr=0x4 returns the old value unchanged.
- Wrap: DEPTH_WORDS=64. Write addr=0x100 with 0xA5A5A5A5 -> read addr=0x0 returns 0xA5A5A5A5.
- WAIT_STATES=3. Write accepted, req toggled during WAIT, reset asserted in the 2nd WAIT cycle -> no ready, busy=0 after reset, target word unchanged. A second req during busy produces no extra response.
- With MEMRESP_BYTE_LANE_EN: word=0x11223344, write 0xAABBCCDD with byte_en=0101 -> read returns 0x11BB33DD.
